// File: rtl/rv32_memory_responder_pkg.sv
// Shared memory-interface types: access widths, exception mask bits and bank IDs.
// Imported by the responder top and its lane-alignment helper.
package rv32_memory_responder_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    // Several bits may be raised together, so this is a mask, not an enum.
    typedef logic [2:0] mem_exception_mask_t;

    localparam mem_exception_mask_t MEM_EXCEPTION_NONE               = 3'b000;
    localparam mem_exception_mask_t MEM_EXCEPTION_MISALIGNED         = 3'b001;
    localparam mem_exception_mask_t MEM_EXCEPTION_ADDR_OUT_OF_BOUNDS = 3'b010;
    localparam mem_exception_mask_t MEM_EXCEPTION_WRITE_READONLY     = 3'b100;

    localparam logic [3:0] MMU_BANK_INSTR = 4'h0;
    localparam logic [3:0] MMU_BANK_DATA  = 4'h1;

endpackage

// File: rtl/rv32_mem_lane_align.sv
// Combinational lane decode: byte enables, write/read shifts, read mask and
// misalignment for a byte, half or word access at a given byte lane.
module rv32_mem_lane_align
    import rv32_memory_responder_pkg::*;
(
    input  mem_access_t access,
    input  logic [1:0]  lane,
    output logic [3:0]  byte_ena,
    output logic [4:0]  wr_shift,
    output logic [4:0]  rd_shift,
    output logic [31:0] rd_mask,
    output logic        misaligned
);

    always_comb begin
        byte_ena   = 4'b0000;
        wr_shift   = {lane, 3'b000};
        rd_shift   = {lane, 3'b000};
        rd_mask    = 32'h0000_0000;
        misaligned = 1'b0;
        case (access)
            MEM_ACCESS_BYTE: begin
                byte_ena = 4'b0001 << lane;
                rd_mask  = 32'h0000_00FF;
            end
            MEM_ACCESS_HALF: begin
                byte_ena   = 4'b0011 << lane;
                rd_mask    = 32'h0000_FFFF;
                misaligned = lane[0];
            end
            MEM_ACCESS_WORD: begin
                byte_ena   = 4'b1111;
                rd_mask    = 32'hFFFF_FFFF;
                misaligned = (lane != 2'b00);
            end
            // Unknown access codes are reported as misaligned.
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv32_memory_responder.sv
// One memory-map bank: word storage with byte/half/word writes and a one-cycle
// registered read/exception response. Optional MEM_CYCLE_COUNTER_EN maps a cycle counter.
module rv32_memory_responder
    import rv32_memory_responder_pkg::*;
#(
    parameter logic [3:0] BANK      = MMU_BANK_DATA,
    parameter int         DEPTH     = 512,
    parameter bit         READ_ONLY = 1'b0,
    parameter string      INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr,
    input  logic [31:0]         wr_data,
    input  logic                wr_ena,
    input  mem_access_t         access,
    output logic [31:0]         rd_data,
    output mem_exception_mask_t exception
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [31:0]         mem [DEPTH];
    logic [25:0]         off;
    logic [1:0]          lane;
    logic [ADDR_W-1:0]   idx;
    logic                in_bank;
    logic                in_range;
    logic                is_ctr;
    logic [3:0]          byte_ena;
    logic [4:0]          wr_shift;
    logic [4:0]          rd_shift;
    logic [31:0]         rd_mask;
    logic                misaligned;
    logic [31:0]         wr_word;
    logic [31:0]         src_word;
    logic                wr_commit;
    mem_exception_mask_t exc_next;

    rv32_mem_lane_align u_lane_align (
        .access     (access),
        .lane       (lane),
        .byte_ena   (byte_ena),
        .wr_shift   (wr_shift),
        .rd_shift   (rd_shift),
        .rd_mask    (rd_mask),
        .misaligned (misaligned)
    );

    assign off     = addr[27:2];
    assign lane    = addr[1:0];
    assign in_bank = (addr[31:28] == BANK);
    // Full-width compare before truncation so high offsets never alias into storage.
    assign in_range = in_bank && ({6'd0, off} < 32'(DEPTH));
    assign idx      = off[ADDR_W-1:0];

`ifdef MEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_ctr;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_ctr <= 32'd0;
        end else begin
            cycle_ctr <= cycle_ctr + 32'd1;
        end
    end

    assign is_ctr   = in_bank && (off == 26'h3FF_FFFF);
    assign src_word = is_ctr ? cycle_ctr : mem[idx];
`else
    assign is_ctr   = 1'b0;
    assign src_word = mem[idx];
`endif

    always_comb begin
        exc_next = MEM_EXCEPTION_NONE;
        if (!(in_range || is_ctr)) begin
            exc_next = exc_next | MEM_EXCEPTION_ADDR_OUT_OF_BOUNDS;
        end
        if (misaligned) begin
            exc_next = exc_next | MEM_EXCEPTION_MISALIGNED;
        end
        if (wr_ena && (READ_ONLY || is_ctr)) begin
            exc_next = exc_next | MEM_EXCEPTION_WRITE_READONLY;
        end
    end

    assign wr_word   = wr_data << wr_shift;
    assign wr_commit = wr_ena && (exc_next == MEM_EXCEPTION_NONE);

    // Storage is never cleared; reset only blocks a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_ena[i]) begin
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data   <= 32'd0;
            exception <= MEM_EXCEPTION_NONE;
        end else begin
            exception <= exc_next;
            if (exc_next == MEM_EXCEPTION_NONE) begin
                rd_data <= (src_word >> rd_shift) & rd_mask;
            end else begin
                rd_data <= 32'd0;
            end
        end
    end

endmodule
